// File: rtl/pacman_vga_frame_sync.sv
// -----------------------------------------------------------------------------
// pacman_vga_frame_sync
//
// Purpose:
//   Generates 640x480@60 VGA timing for the HDMI encoder and the sprite/maze
//   renderer. The pixel counters advance on a one-cycle pixel clock-enable.
//   The module also copies the AXI register-bank outputs into frame-stable
//   shadow registers at vblank start. As a result, the renderer never sees a
//   register update in the middle of a frame.
//
// Ports:
//   ACLK           system clock, shared with the AXI register bank
//   ARESETN        synchronous active-low reset
//   pix_ce         pixel clock-enable, one ACLK cycle wide
//   reg_in         live register-bank outputs, reg0 in [31:0]
//   hold           1 = software is mid-update, so the shadow load waits
//   hsync, vsync   active-low syncs
//   vde            active-video enable
//   drawX, drawY   current pixel column / row
//   reg_shadow     frame-stable copy of reg_in
//   shadow_upd     1-cycle pulse when reg_shadow loads
//   frame_start    1-cycle pulse when the counters wrap to (0,0)
//   frame_cnt      completed-frame counter, wraps modulo 2^16
//   shadow_state   debug view of the shadow-latch FSM (1 = load pending)
//
// Handshake note: this block has no valid/ready interfaces. pix_ce is a plain
// qualifier. Every counter and timing output moves only on an ACLK edge where
// pix_ce=1. The shadow latch is not gated by pix_ce, so it may load on any
// edge inside vblank.
// -----------------------------------------------------------------------------
module pacman_vga_frame_sync #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int NUM_REGS = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    pix_ce,
  input  logic [NUM_REGS*32-1:0]  reg_in,
  input  logic                    hold,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    vde,
  output logic [9:0]              drawX,
  output logic [9:0]              drawY,
  output logic [NUM_REGS*32-1:0]  reg_shadow,
  output logic                    shadow_upd,
  output logic                    frame_start,
  output logic [15:0]             frame_cnt,
  output logic                    shadow_state
);

  localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  typedef enum logic {
    SH_IDLE    = 1'b0,
    SH_PENDING = 1'b1
  } sh_state_t;

  logic [9:0] hc;
  logic [9:0] vc;
  logic [9:0] hc_nxt;
  logic [9:0] vc_nxt;
  logic       line_end;
  logic       frame_end;
  logic       wrap;
  logic       vblank_entry;
  logic       in_vblank;
  logic       load;
  sh_state_t  state;
  sh_state_t  state_nxt;

  // Next counter position. The timing outputs are registered from this value,
  // so they always describe the (hc,vc) the counters hold after the edge.
  always_comb begin
    line_end  = (hc == 10'(HT - 1));
    frame_end = line_end && (vc == 10'(VT - 1));
    hc_nxt    = line_end ? 10'd0 : hc + 10'd1;
    vc_nxt    = vc;
    if (line_end) begin
      vc_nxt = frame_end ? 10'd0 : vc + 10'd1;
    end
    wrap         = pix_ce && frame_end;
    // This is the edge on which the counters enter (0, V_ACTIVE).
    vblank_entry = pix_ce && line_end && (vc == 10'(V_ACTIVE - 1));
    in_vblank    = (vc >= 10'(V_ACTIVE));
  end

  // Shadow-latch FSM: state register.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state <= SH_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Shadow-latch FSM: next state.
  // A load deferred by hold is retried on every vblank edge. It is dropped
  // once the counters wrap back to the active frame.
  always_comb begin
    state_nxt = state;
    case (state)
      SH_IDLE: begin
        if (vblank_entry && hold) begin
          state_nxt = SH_PENDING;
        end
      end
      SH_PENDING: begin
        if (in_vblank && !hold) begin
          state_nxt = SH_IDLE;
        end else if (wrap) begin
          state_nxt = SH_IDLE;
        end
      end
      default: state_nxt = SH_IDLE;
    endcase
  end

  // Shadow-latch FSM: outputs.
  always_comb begin
    load         = 1'b0;
    shadow_state = (state == SH_PENDING);
    case (state)
      SH_IDLE:    load = vblank_entry && !hold;
      SH_PENDING: load = in_vblank && !hold;
      default:    load = 1'b0;
    endcase
  end

  // Counters, timing outputs, shadow registers and frame bookkeeping.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      hc          <= '0;
      vc          <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      vde         <= 1'b0;
      reg_shadow  <= '0;
      shadow_upd  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      shadow_upd  <= load;
      frame_start <= wrap;
      if (load) begin
        reg_shadow <= reg_in;
      end
      if (pix_ce) begin
        hc    <= hc_nxt;
        vc    <= vc_nxt;
        hsync <= ~((hc_nxt >= 10'(HS_START)) && (hc_nxt < 10'(HS_END)));
        vsync <= ~((vc_nxt >= 10'(VS_START)) && (vc_nxt < 10'(VS_END)));
        vde   <= (hc_nxt < 10'(H_ACTIVE)) && (vc_nxt < 10'(V_ACTIVE));
        if (frame_end) begin
          frame_cnt <= frame_cnt + 16'd1;
        end
      end
    end
  end

  assign drawX = hc;
  assign drawY = vc;

endmodule

// File: tb/tb_pacman_vga_frame_sync.sv
// -----------------------------------------------------------------------------
// tb_pacman_vga_frame_sync
//
// Self-checking bench for pacman_vga_frame_sync. The DUT is built with a
// reduced raster (32x17 totals) so that many full frames fit in a short run.
// The sync, porch and active boundaries keep the same relative structure.
//
// The reference model tracks a single linear pixel index per frame. Column and
// row come from plain division. Every timing output is recomputed from the
// raster rules. Shadow loads are pushed onto an expected queue and popped
// when the DUT reports shadow_upd.
// -----------------------------------------------------------------------------
module tb_pacman_vga_frame_sync;

  localparam int H_ACTIVE = 20;
  localparam int H_FP     = 3;
  localparam int H_SYNC   = 5;
  localparam int H_BP     = 4;
  localparam int V_ACTIVE = 10;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 3;
  localparam int NUM_REGS = 4;
  localparam int W        = NUM_REGS * 32;
  localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = HT * VT;

  // ---------------- clock / reset ----------------
  logic          ACLK;
  logic          ARESETN;
  logic          pix_ce;
  logic [W-1:0]  reg_in;
  logic          hold;
  logic          hsync;
  logic          vsync;
  logic          vde;
  logic [9:0]    drawX;
  logic [9:0]    drawY;
  logic [W-1:0]  reg_shadow;
  logic          shadow_upd;
  logic          frame_start;
  logic [15:0]   frame_cnt;
  logic          shadow_state;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  pacman_vga_frame_sync #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .NUM_REGS(NUM_REGS)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .pix_ce       (pix_ce),
    .reg_in       (reg_in),
    .hold         (hold),
    .hsync        (hsync),
    .vsync        (vsync),
    .vde          (vde),
    .drawX        (drawX),
    .drawY        (drawY),
    .reg_shadow   (reg_shadow),
    .shadow_upd   (shadow_upd),
    .frame_start  (frame_start),
    .frame_cnt    (frame_cnt),
    .shadow_state (shadow_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_p;       // linear pixel index within the frame
  bit           m_fresh;   // no pixel step since reset: outputs hold reset values
  bit           m_pend;
  bit           m_upd;
  bit           m_fs;
  bit           m_load;
  int           m_row;
  logic [W-1:0] m_shadow;
  logic [15:0]  m_fcnt;
  logic [W-1:0] exp_q[$];

  always @(posedge ACLK) begin
    if (!ARESETN) begin
      m_p      = 0;
      m_fresh  = 1'b1;
      m_pend   = 1'b0;
      m_upd    = 1'b0;
      m_fs     = 1'b0;
      m_shadow = '0;
      m_fcnt   = '0;
      exp_q.delete();
    end else begin
      m_row  = m_p / HT;
      m_load = 1'b0;
      m_fs   = 1'b0;
      if (pix_ce && (m_p + 1 == V_ACTIVE * HT)) begin
        if (hold) m_pend = 1'b1;
        else      m_load = 1'b1;
      end else if (m_pend && m_row >= V_ACTIVE && !hold) begin
        m_load = 1'b1;
      end else if (m_pend && pix_ce && m_p == FRAME - 1) begin
        m_pend = 1'b0;
      end
      if (m_load) begin
        m_pend   = 1'b0;
        m_shadow = reg_in;
        exp_q.push_back(reg_in);
      end
      m_upd = m_load;
      if (pix_ce) begin
        if (m_p == FRAME - 1) begin
          m_fs   = 1'b1;
          m_fcnt = m_fcnt + 16'd1;
        end
        m_p     = (m_p + 1) % FRAME;
        m_fresh = 1'b0;
      end
    end
  end

  // Compare every DUT output with the model, away from the active edge.
  bit chk_en;
  always @(negedge ACLK) begin
    if (chk_en) begin
      int hc;
      int vc;
      hc = m_p % HT;
      vc = m_p / HT;
      check_eq("drawX", drawX, hc);
      check_eq("drawY", drawY, vc);
      check_eq("hsync", hsync, m_fresh ? 1 :
               !(hc >= H_ACTIVE + H_FP && hc < H_ACTIVE + H_FP + H_SYNC));
      check_eq("vsync", vsync, m_fresh ? 1 :
               !(vc >= V_ACTIVE + V_FP && vc < V_ACTIVE + V_FP + V_SYNC));
      check_eq("vde", vde, m_fresh ? 0 : (hc < H_ACTIVE && vc < V_ACTIVE));
      check_eq("frame_start", frame_start, m_fs);
      check_eq("frame_cnt", frame_cnt, m_fcnt);
      check_eq("reg_shadow", reg_shadow, m_shadow);
      check_eq("shadow_upd", shadow_upd, m_upd);
      check_eq("shadow_pending", shadow_state, m_pend);
      if (m_upd && exp_q.size() != 0) begin
        check_eq("upd_value", reg_shadow, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  int ce_mode;    // 0: every 4th cycle, 1: random, 2: always, 3: off
  int hold_mode;  // 0: off, 1: random, 2: across vblank start, 3: until wrap
  bit rand_regs;
  int cyc;

  task automatic step();
    int vc;
    @(negedge ACLK);
    cyc++;
    vc = m_p / HT;
    case (ce_mode)
      0:       pix_ce = (cyc % 4 == 0);
      1:       pix_ce = ($urandom_range(0, 1) == 1);
      2:       pix_ce = 1'b1;
      default: pix_ce = 1'b0;
    endcase
    case (hold_mode)
      1:       if ($urandom_range(0, 15) == 0) hold = ~hold;
      2:       hold = (vc >= V_ACTIVE - 1 && vc <= V_ACTIVE + 1);
      3:       hold = (vc >= V_ACTIVE - 1);
      default: hold = 1'b0;
    endcase
    if (rand_regs && $urandom_range(0, 31) == 0) begin
      for (int i = 0; i < NUM_REGS; i++) reg_in[i*32 +: 32] = $urandom;
    end
  endtask

  task automatic run_until(input int x, input int y, input int budget);
    int  n;
    bit  found;
    n     = 0;
    found = 1'b0;
    while (n < budget && !found) begin
      if (m_p % HT == x && m_p / HT == y) found = 1'b1;
      else begin
        step();
        n++;
      end
    end
    check_eq("run_until_reached", found, 1);
  endtask

  task automatic run_until_wrap(input int budget);
    int n;
    bit found;
    n     = 0;
    found = 1'b0;
    while (n < budget && !found) begin
      step();
      n++;
      if (m_fs) found = 1'b1;
    end
    check_eq("wrap_reached", found, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    chk_en    = 1'b0;
    ARESETN   = 1'b0;
    pix_ce    = 1'b0;
    hold      = 1'b0;
    reg_in    = '0;
    ce_mode   = 3;
    hold_mode = 0;
    rand_regs = 1'b0;

    repeat (3) @(negedge ACLK);
    chk_en  = 1'b1;
    step();
    ARESETN = 1'b1;

    // Every 4th cycle pixel rate, fixed register values, first frame wrap.
    reg_in  = {32'd4, 32'd3, 32'd2, 32'd1};
    ce_mode = 0;
    run_until(1, V_ACTIVE, 4 * FRAME);
    check_eq("shadow_plan_load", reg_shadow, {32'd4, 32'd3, 32'd2, 32'd1});
    run_until_wrap(4 * FRAME);
    check_eq("fcnt_first_wrap", frame_cnt, 1);
    run_until(0, V_ACTIVE / 2, 4 * FRAME);
    reg_in = {32'd8, 32'd7, 32'd6, 32'd5};
    run_until(0, V_ACTIVE - 1, 4 * FRAME);
    check_eq("shadow_plan_stable", reg_shadow, {32'd4, 32'd3, 32'd2, 32'd1});
    run_until(1, V_ACTIVE, 4 * FRAME);
    check_eq("shadow_plan_reload", reg_shadow, {32'd8, 32'd7, 32'd6, 32'd5});

    // Hold across vblank start, released inside vblank.
    ce_mode   = 1;
    rand_regs = 1'b1;
    hold_mode = 2;
    repeat (3) run_until_wrap(3 * FRAME);

    // Hold until wrap: the load is abandoned for the whole frame.
    hold_mode = 3;
    repeat (2) run_until_wrap(3 * FRAME);

    // Random hold toggling under a random pixel rate.
    hold_mode = 1;
    repeat (4) run_until_wrap(3 * FRAME);

    // Freeze: no pixel enables for 1000 cycles.
    hold_mode = 0;
    hold      = 1'b0;
    ce_mode   = 3;
    repeat (1000) step();

    // Reset asserted mid-line.
    ce_mode = 1;
    run_until(H_ACTIVE / 2 + 1, V_ACTIVE / 2, 3 * FRAME);
    ARESETN = 1'b0;
    step();
    ARESETN = 1'b1;
    check_eq("rst_drawX", drawX, 0);
    check_eq("rst_vde", vde, 0);
    check_eq("rst_shadow", reg_shadow, 0);

    // Reset coinciding with the vblank-start latch edge.
    ce_mode = 2;
    run_until(HT - 1, V_ACTIVE - 1, 2 * FRAME);
    ARESETN = 1'b0;
    step();
    ARESETN = 1'b1;
    check_eq("rst_latch_shadow", reg_shadow, 0);
    check_eq("rst_latch_upd", shadow_upd, 0);

    // frame_cnt rollover: preload 65535, then run to the next wrap.
    ce_mode = 3;
    step();
    force dut.frame_cnt = 16'hFFFF;
    m_fcnt = 16'hFFFF;
    step();
    step();
    release dut.frame_cnt;
    step();
    check_eq("fcnt_preload", frame_cnt, 16'hFFFF);
    ce_mode = 2;
    run_until_wrap(2 * FRAME);
    check_eq("fcnt_rollover", frame_cnt, 0);
    check_eq("fcnt_wrap_pulse", frame_start, 1);

    repeat (10) step();
    check_eq("exp_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
